// File: rtl/out_ascii_fmt_pkg.sv
// Shared constants and state encoding for the OUTBOX-to-UART decimal formatter.
package out_ascii_fmt_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_CONV,
    ST_SIGN,
    ST_HUND,
    ST_TENS,
    ST_UNITS,
    ST_TERM
  } state_t;

  // First digit state after the sign (or straight after CONV): leading zeros are skipped.
  function automatic state_t first_digit(input logic [1:0] h, input logic [3:0] t);
    if (h != 2'd0)      return ST_HUND;
    else if (t != 4'd0) return ST_TENS;
    else                return ST_UNITS;
  endfunction

endpackage

// File: rtl/out_ascii_fmt_if.sv
// OUTBOX read side and UART TX write side of the formatter, bundled.
interface out_ascii_fmt_if;
  logic       i_empty_n;
  logic [7:0] i_data;
  logic       o_pop;
  logic       i_busy;
  logic       o_wr;
  logic [7:0] o_data;
  logic       o_idle;

  modport master (
    input  i_empty_n, i_data, i_busy,
    output o_pop, o_wr, o_data, o_idle
  );

  modport slave (
    output i_empty_n, i_data, i_busy,
    input  o_pop, o_wr, o_data, o_idle
  );
endinterface

// File: rtl/out_ascii_fmt_bin2dec3.sv
// Combinational 8-bit binary to three decimal digits, compare/subtract chain, no divider.
module bin2dec3 (
  input  logic [7:0] i_mag,
  output logic [1:0] o_h,
  output logic [3:0] o_t,
  output logic [3:0] o_u
);

  logic [7:0] rem;

  // Peel off hundreds, then up to nine tens; what remains is the units digit.
  always_comb begin
    o_h = '0;
    o_t = '0;
    rem = i_mag;
    if (rem >= 8'd200) begin
      o_h = 2'd2;
      rem = rem - 8'd200;
    end else if (rem >= 8'd100) begin
      o_h = 2'd1;
      rem = rem - 8'd100;
    end
    for (int unsigned k = 0; k < 9; k++) begin
      if (rem >= 8'd10) begin
        rem = rem - 8'd10;
        o_t = o_t + 4'd1;
      end
    end
    o_u = rem[3:0];
  end

endmodule

// File: rtl/out_ascii_fmt.sv
// Pops one OUTBOX value, prints it as ASCII decimal (optional '-') plus a terminator to txuartlite.
module out_ascii_fmt
  import out_ascii_fmt_pkg::*;
#(
  parameter bit         SIGNED = 1'b1,
  parameter logic [7:0] TERM   = 8'h0A
) (
  input  logic            clk,
  input  logic            i_rst_n,
  out_ascii_fmt_if.master bus
);

  state_t     state_q, state_d;
  logic [7:0] cap_q;
  logic       neg_q;
  logic [1:0] h_q;
  logic [3:0] t_q, u_q;
  logic       wr_q;
  logic [7:0] data_q;

  logic       is_neg;
  logic [7:0] mag;
  logic [1:0] h;
  logic [3:0] t, u;
  logic       wr, pop, emit;
  logic [7:0] ch;

  // Two's complement negate in 8 bits still yields 128 (0x80) for -128, so no 9th bit is kept.
  assign is_neg = SIGNED && cap_q[7];
  assign mag    = is_neg ? (~cap_q) + 8'd1 : cap_q;

  bin2dec3 u_bin2dec3 (
    .i_mag (mag),
    .o_h   (h),
    .o_t   (t),
    .o_u   (u)
  );

  // State, captured value, digit registers and write-guard/data history.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cap_q   <= '0;
      neg_q   <= 1'b0;
      h_q     <= '0;
      t_q     <= '0;
      u_q     <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr;
      data_q  <= bus.o_data;
      if (state_q == ST_POP) cap_q <= bus.i_data;
      if (state_q == ST_CONV) begin
        neg_q <= is_neg;
        h_q   <= h;
        t_q   <= t;
        u_q   <= u;
      end
    end
  end

  // Next state and strobes; a character state writes once TX is free and the guard cycle has passed.
  always_comb begin
    state_d = state_q;
    wr      = 1'b0;
    pop     = 1'b0;
    ch      = data_q;
    emit    = i_rst_n && !bus.i_busy && !wr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_empty_n) state_d = ST_POP;
      end
      ST_POP: begin
        pop     = i_rst_n;
        state_d = ST_CONV;
      end
      ST_CONV: begin
        state_d = is_neg ? ST_SIGN : first_digit(h, t);
      end
      ST_SIGN: begin
        ch = ASCII_MINUS;
        if (emit) begin
          wr      = 1'b1;
          state_d = first_digit(h_q, t_q);
        end
      end
      ST_HUND: begin
        ch = ASCII_ZERO + {6'd0, h_q};
        if (emit) begin
          wr      = 1'b1;
          state_d = ST_TENS;
        end
      end
      ST_TENS: begin
        ch = ASCII_ZERO + {4'd0, t_q};
        if (emit) begin
          wr      = 1'b1;
          state_d = ST_UNITS;
        end
      end
      ST_UNITS: begin
        ch = ASCII_ZERO + {4'd0, u_q};
        if (emit) begin
          wr      = 1'b1;
          state_d = ST_TERM;
        end
      end
      ST_TERM: begin
        ch = TERM;
        if (emit) begin
          wr      = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.o_pop  = pop;
  assign bus.o_wr   = wr;
  assign bus.o_data = wr ? ch : data_q;
  assign bus.o_idle = (state_q == ST_IDLE);

  // neg_q is kept for debug visibility of the converted value's sign.
  logic unused_neg;
  assign unused_neg = neg_q;

endmodule

// File: tb/tb_out_ascii_fmt.sv
// Scoreboard bench: channel 0 is SIGNED=1, channel 1 is SIGNED=0, each with an OUTBOX and a TX busy model.
module tb_out_ascii_fmt;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  bit         busy_hold [2];
  logic [7:0] outbox    [2][$];
  logic [7:0] exp_q     [2][$];
  bit         in_flight [2];
  int         pops      [2];
  int         pushed    [2];
  int         chars_seen[2];
  logic       idle_s    [2];
  logic       wr_a      [2];
  logic       pop_a     [2];
  logic [7:0] data_a    [2];

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference: decimal text of the value as the terminal should show it, then newline.
  task automatic push(input int c, input logic [7:0] v);
    int    n;
    string s;
    n = (c == 0 && v > 8'd127) ? int'(v) - 256 : int'(v);
    s = $sformatf("%0d", n);
    for (int i = 0; i < s.len(); i++) exp_q[c].push_back(s[i]);
    exp_q[c].push_back(8'h0A);
    outbox[c].push_back(v);
    pushed[c]++;
  endtask

  task automatic drain(input int c, input string name);
    int n = 0;
    while ((exp_q[c].size() != 0 || outbox[c].size() != 0 || idle_s[c] !== 1'b1) && n < 20000) begin
      @(negedge clk); #1;
      n++;
    end
    check(name, (n < 20000) ? 1 : 0, 1);
  endtask

  task automatic wait_chars(input int c, input int target, input string name);
    int n = 0;
    while (chars_seen[c] < target && n < 5000) begin
      @(negedge clk); #1;
      n++;
    end
    check(name, (n < 5000) ? 1 : 0, 1);
  endtask

  for (genvar c = 0; c < 2; c++) begin : g_ch
    out_ascii_fmt_if bus ();

    out_ascii_fmt #(
      .SIGNED ((c == 0) ? 1'b1 : 1'b0),
      .TERM   (8'h0A)
    ) dut (
      .clk     (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
    );

    int tx_left;
    bit tx_start;
    bit pop_s;
    bit wr_s;
    bit prev_wr;

    // OUTBOX (first-word-fall-through) and a txuartlite-like busy with one cycle of lag.
    initial begin
      bus.i_empty_n = 1'b0;
      bus.i_data    = 8'h00;
      bus.i_busy    = 1'b0;
      tx_left       = 0;
      tx_start      = 1'b0;
      forever begin
        @(negedge clk);
        pop_s = bus.o_pop;
        wr_s  = bus.o_wr;
        @(posedge clk); #1;
        if (pop_s && outbox[c].size() > 0) void'(outbox[c].pop_front());
        if (tx_start) begin
          tx_left  = int'($urandom_range(0, 12));
          tx_start = 1'b0;
        end else if (tx_left > 0) begin
          tx_left--;
        end
        if (wr_s) tx_start = 1'b1;
        bus.i_empty_n = (outbox[c].size() > 0);
        bus.i_data    = (outbox[c].size() > 0) ? outbox[c][0] : 8'h00;
        bus.i_busy    = (tx_left > 0) || busy_hold[c];
      end
    end

    // Monitor: pops expected characters and checks pop/write protocol.
    initial begin
      prev_wr = 1'b0;
      forever begin
        @(negedge clk);
        idle_s[c] = bus.o_idle;
        wr_a[c]   = bus.o_wr;
        pop_a[c]  = bus.o_pop;
        data_a[c] = bus.o_data;
        if (bus.o_pop === 1'b1) begin
          pops[c]++;
          check($sformatf("ch%0d_pop_one_in_flight", c), int'(in_flight[c]), 0);
          in_flight[c] = 1'b1;
        end
        if (bus.o_wr === 1'b1) begin
          check($sformatf("ch%0d_wr_spacing", c), int'(prev_wr), 0);
          check($sformatf("ch%0d_wr_while_busy", c), int'(bus.i_busy), 0);
          if (exp_q[c].size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL ch%0d_unexpected_char: actual=0x%0h required=none", c, bus.o_data);
          end else begin
            check($sformatf("ch%0d_char", c), int'(bus.o_data), int'(exp_q[c].pop_front()));
          end
          chars_seen[c]++;
          if (bus.o_data == 8'h0A) in_flight[c] = 1'b0;
        end
        prev_wr = (bus.o_wr === 1'b1);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    for (int c = 0; c < 2; c++) begin
      check($sformatf("ch%0d_rst_wr", c), int'(wr_a[c]), 0);
      check($sformatf("ch%0d_rst_pop", c), int'(pop_a[c]), 0);
      check($sformatf("ch%0d_rst_data", c), int'(data_a[c]), 0);
      check($sformatf("ch%0d_rst_idle", c), int'(idle_s[c]), 1);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed values from the plan plus signed boundaries.
    push(0, 8'h00);
    drain(0, "ch0_drain_zero");
    check("ch0_idle_after_zero", int'(idle_s[0]), 1);
    push(0, 8'h7F);
    push(0, 8'h80);
    drain(0, "ch0_drain_7f_80");
    check("ch0_pops_after_7f_80", pops[0], 3);
    push(0, 8'h81);
    push(0, 8'hFF);
    push(0, 8'h0A);
    push(1, 8'hFF);
    push(1, 8'h64);
    push(1, 8'h0A);
    push(1, 8'h00);
    push(1, 8'h09);
    drain(0, "ch0_drain_bounds");
    drain(1, "ch1_drain_directed");

    // Randomized values with random gaps on both channels at once.
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 25)) @(negedge clk);
          push(0, 8'($urandom_range(0, 255)));
        end
      end
      begin
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 25)) @(negedge clk);
          push(1, 8'($urandom_range(0, 255)));
        end
      end
    join
    drain(0, "ch0_drain_random");
    drain(1, "ch1_drain_random");

    // Busy held for 500 cycles while the tens digit of 123 is pending.
    seen = chars_seen[0];
    push(0, 8'h7B);
    wait_chars(0, seen + 1, "ch0_wait_hund");
    busy_hold[0] = 1'b1;
    repeat (500) @(negedge clk);
    #1;
    check("ch0_hold_no_wr", chars_seen[0] - seen, 1);
    busy_hold[0] = 1'b0;
    drain(0, "ch0_drain_hold");

    // Reset one cycle after the minus sign of -5 has been written.
    seen = chars_seen[0];
    push(0, 8'hFB);
    wait_chars(0, seen + 1, "ch0_wait_sign");
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q[0].delete();
    in_flight[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("ch0_midrst_wr", int'(wr_a[0]), 0);
    check("ch0_midrst_pop", int'(pop_a[0]), 0);
    check("ch0_midrst_idle", int'(idle_s[0]), 1);
    check("ch0_midrst_chars", chars_seen[0] - seen, 1);
    push(0, 8'hFB);
    drain(0, "ch0_drain_after_rst");

    for (int c = 0; c < 2; c++) begin
      check($sformatf("ch%0d_total_pops", c), pops[c], pushed[c]);
      check($sformatf("ch%0d_final_idle", c), int'(idle_s[c]), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/out_ascii_fmt.md
# out_ascii_fmt

Output formatter between the HRM-CPU OUTBOX and the UART transmitter. It pops one 8-bit value at a time from the OUTBOX, converts it to ASCII decimal with an optional minus sign and a terminator character, and feeds the characters one per write to `txuartlite`. It replaces the raw byte path `OUTBOX -> TX`, so a terminal shows human-readable numbers.

## Interface
Parameters:
- `SIGNED`, 1: 1 = treat value as two's complement (-128..127); 0 = unsigned (0..255).
- `TERM`, 8'h0A: terminator character sent after the last digit.

Ports:
- `clk` in 1: system clock; single clock domain.
- `i_rst_n` in 1: reset, synchronous, active-low.
- `i_empty_n` in 1: OUTBOX not empty.
- `i_data` in 8: OUTBOX head value; first-word-fall-through, valid while `i_empty_n`=1.
- `o_pop` out 1: one-cycle OUTBOX read strobe (drives `cpu_out_rd`).
- `i_busy` in 1: UART TX busy (`o_busy` of `txuartlite`).
- `o_wr` out 1: one-cycle write strobe to the TX.
- `o_data` out 8: character to send; valid in the `o_wr` cycle.
- `o_idle` out 1: 1 when in IDLE with no character pending.

## Operation
- States:
  - IDLE -> POP when `i_empty_n` and not `o_pop`.
  - POP (`o_pop`=1; `i_data` captured at the closing edge) -> CONV.
  - CONV (split into digits) -> SIGN / HUND / TENS / UNITS, whichever is first needed.
  - SIGN -> HUND / TENS / UNITS -> TERM -> IDLE.
- Magnitude:
  - `SIGNED`=1 and bit7=1: `mag` = (~v)+1, computed 9-bit so 0x80 gives 128; the sign flag is set.
  - Otherwise `mag` = v.
- Digits:
  - `h` = `mag`/100 (0..2), `t` = (`mag` mod 100)/10, `u` = `mag` mod 10.
  - Each character is 8'h30 + digit; SIGN sends 8'h2D.
- Leading-zero suppression:
  - HUND is sent only if `h`≠0.
  - TENS is sent if `h`≠0 or `t`≠0.
  - UNITS is always sent.
- Emit rule, for each character state:
  - `o_wr`=1 for exactly one cycle when `i_busy`=0 and `o_wr` was 0 in the previous cycle.
  - This guard cycle covers the one-cycle lag before `txuartlite` raises busy.
  - The state advances on the edge that ends the `o_wr` cycle.
- `o_data` holds its value until the next `o_wr`.
- No new pop happens until TERM has been written; there is at most one value in flight.

## Timing
- Reset values: `o_pop`=0, `o_wr`=0, `o_data`=8'h00, `o_idle`=1, state=IDLE, capture register=0.
- Latency:
  - `i_empty_n` rises before edge E0; `o_pop` is high in cycle E0..E1.
  - CONV occupies cycle E1..E2.
  - The first `o_wr` is in cycle E2..E3 if `i_busy`=0.
- Character spacing: at least 2 cycles between `o_wr` pulses (the guard cycle); otherwise limited by `i_busy`.
- `i_busy` held high: the FSM waits indefinitely in the current state with `o_wr`=0; no character is lost or repeated.
- Simultaneous `i_empty_n` and a pending write: the pop is deferred until IDLE.
- `i_empty_n` dropping while not in IDLE: no effect.
- Reset mid-operation:
  - Immediate return to IDLE; `o_wr` and `o_pop` go low next cycle.
  - Unsent characters are dropped, and a value already popped is lost.
  - The TX may finish a character already accepted.

## Structure
- Shared package/header holds:
  - `ASCII_ZERO`=8'h30 and `ASCII_MINUS`=8'h2D.
  - State encoding constants for IDLE, POP, CONV, SIGN, HUND, TENS, UNITS, TERM.
- Sub-module `bin2dec3`: combinational, 8-bit magnitude in, 2-bit `h` and 4-bit `t`/`u` out, built from a compare/subtract chain with no divider. It is registered in CONV.
- Top-level hookup:
  - `o_pop` -> `cpu_out_rd`
  - `o_wr` -> TX `i_wr`
  - `o_data` -> TX `i_data`

## Test plan
- `SIGNED`=1, push 0x00 -> `o_wr` bytes 0x30, 0x0A; one `o_pop`; `o_idle` returns to 1.
- Push 0x7F then 0x80 back-to-back:
  - Expect 0x31 0x32 0x37 0x0A, then 0x2D 0x31 0x32 0x38 0x0A.
  - Exactly two `o_pop` pulses; the second comes only after the first 0x0A.
- `SIGNED`=0:
  - Push 0xFF -> "255\n".
  - Push 0x64 -> 0x31 0x30 0x30 0x0A (internal zeros kept).
  - Push 0x0A -> "10\n".
- Hold `i_busy`=1 for 500 cycles during TENS -> no `o_wr`; after release, exactly one 0x3? is written, and no pulse comes within 1 cycle of another.
- Drive `i_busy` from a real `txuartlite` model -> every character is accepted exactly once; the serial line decodes to "-5\n" for 0xFB.
- Assert `i_rst_n`=0 for one cycle after the sign has been sent -> next cycle `o_wr`=0 and state IDLE; the OUTBOX value after reset prints complete, with no stale digits.
